// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch stage.
//   error_t        fetch error code delivered to decode
//   fetch_state_t  fetch controller states
//   fetch_data_t   one fetched entry {valid, pc, raw_instr, error}
package fetch_unit_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef logic [XLEN-1:0] u64;
    typedef logic [ILEN-1:0] u32;

    localparam u64 PC_RESET = 64'h8000_0000;

    typedef enum logic {
        NONE           = 1'b0,
        INSTR_MISALIGN = 1'b1
    } error_t;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        DISCARD  = 2'd1,
        MIS_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic   valid;
        u64     pc;
        u32     raw_instr;
        error_t error;
    } fetch_data_t;

    localparam fetch_data_t FETCH_DATA_EMPTY = '{valid: 1'b0, pc: '0, raw_instr: '0, error: NONE};

    // Instructions are 4-byte aligned; any low PC bit set is a misaligned fetch.
    function automatic logic pc_misaligned(input u64 pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: single-entry holding buffer behind the fetch output slot.
//   clk, reset   clock, synchronous active-low reset
//   push_i       load data_i (wins over pop_i in the same cycle)
//   pop_i        empty the entry
//   flush_i      empty the entry, highest priority
//   data_i       entry to store
//   data_o       stored entry
//   full_o       entry is occupied
module fetch_skid
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  fetch_data_t data_i,
    output fetch_data_t data_o,
    output logic        full_o
);

    fetch_data_t entry_q, entry_d;

    // Next entry: flush, then push (replaces on simultaneous pop), then pop.
    always_comb begin
        entry_d = entry_q;
        if (flush_i) begin
            entry_d = FETCH_DATA_EMPTY;
        end else if (push_i) begin
            entry_d       = data_i;
            entry_d.valid = 1'b1;
        end else if (pop_i) begin
            entry_d = FETCH_DATA_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            entry_q <= FETCH_DATA_EMPTY;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign data_o = entry_q;
    assign full_o = entry_q.valid;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, issues one outstanding
// instruction-bus request at a time, flags misaligned PCs without touching
// the bus, and presents a registered slot (plus one skid entry) to decode.
//   clk, reset                 clock, synchronous active-low reset
//   ireq_valid, ireq_addr      instruction-bus request (addr = current PC)
//   iresp_data_ok, iresp_data  bus response completing the request
//   redirect_valid/_pc         flush and restart fetch at redirect_pc
//   stall                      decode cannot take the slot this cycle
//   f_valid, f_pc, f_raw_instr, f_error   output slot to decode
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [ILEN-1:0] iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            f_valid,
    output logic [XLEN-1:0] f_pc,
    output logic [ILEN-1:0] f_raw_instr,
    output error_t          f_error
);

    fetch_state_t state_q, state_d;
    u64           pc_q, pc_d;
    u64           tgt_q, tgt_d;
    fetch_data_t  slot_q, slot_d;

    fetch_data_t  new_entry;
    logic         new_valid;
    logic         req_c;
    logic         consume;
    logic         skid_push, skid_pop, skid_flush, skid_full;
    fetch_data_t  skid_data;

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (skid_push),
        .pop_i   (skid_pop),
        .flush_i (skid_flush),
        .data_i  (new_entry),
        .data_o  (skid_data),
        .full_o  (skid_full)
    );

    // A request is outstanding while fetching an aligned PC with room to land
    // the response, or while waiting to drop a response after a redirect.
    assign req_c      = ((state_q == FETCH) && !pc_misaligned(pc_q) && !skid_full)
                        || (state_q == DISCARD);
    assign ireq_valid = reset && req_c;
    assign ireq_addr  = pc_q;
    assign consume    = slot_q.valid && !stall;

    // Next-state, PC and new-entry generation.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        new_valid = 1'b0;
        new_entry = FETCH_DATA_EMPTY;

        case (state_q)
            FETCH: begin
                if (!skid_full) begin
                    if (pc_misaligned(pc_q)) begin
                        new_valid = 1'b1;
                        new_entry = '{valid: 1'b1, pc: pc_q, raw_instr: '0, error: INSTR_MISALIGN};
                        state_d   = MIS_WAIT;
                    end else if (iresp_data_ok) begin
                        new_valid = 1'b1;
                        new_entry = '{valid: 1'b1, pc: pc_q, raw_instr: iresp_data, error: NONE};
                        pc_d      = pc_q + XLEN'(4);
                    end
                end
            end
            DISCARD: begin
                if (iresp_data_ok) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
            end
            MIS_WAIT: state_d = MIS_WAIT;
            default:  state_d = FETCH;
        endcase

        // Redirect overrides everything; a still-open request must finish first.
        if (redirect_valid) begin
            new_valid = 1'b0;
            if (req_c && !iresp_data_ok) begin
                tgt_d   = redirect_pc;
                state_d = DISCARD;
            end else begin
                pc_d    = redirect_pc;
                state_d = FETCH;
            end
        end
    end

    // Slot/skid movement: consume pulls the skid forward, new entries land in
    // the slot when it frees up and the skid is empty, otherwise in the skid.
    always_comb begin
        slot_d     = slot_q;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_flush = redirect_valid;

        if (redirect_valid) begin
            slot_d = FETCH_DATA_EMPTY;
        end else begin
            if (consume) begin
                slot_d   = skid_full ? skid_data : FETCH_DATA_EMPTY;
                skid_pop = skid_full;
            end
            if (new_valid) begin
                if ((!slot_q.valid || consume) && !skid_full) begin
                    slot_d = new_entry;
                end else begin
                    skid_push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            tgt_q   <= '0;
            slot_q  <= FETCH_DATA_EMPTY;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            slot_q  <= slot_d;
        end
    end

    assign f_valid     = slot_q.valid;
    assign f_pc        = slot_q.pc;
    assign f_raw_instr = slot_q.raw_instr;
    assign f_error     = slot_q.error;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok = 1'b0;
    logic [ILEN-1:0] iresp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            stall = 1'b0;
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic [ILEN-1:0] f_raw_instr;
    error_t          f_error;

    int total = 0;
    int bad   = 0;
    int lat   = 0;

    fetch_data_t exp_q[$];

    fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_raw_instr    (f_raw_instr),
        .f_error        (f_error)
    );

    always #5 clk = ~clk;

    function automatic u32 mem_word(input u64 a);
        return 32'(a) ^ 32'h1357_9BDF;
    endfunction

    // Bus responder with programmable latency plus output scoreboard.
    task automatic bus_and_scoreboard();
        int          cnt = 0;
        logic        discard = 1'b0;
        logic        prev_pend = 1'b0;
        logic        prev_redir = 1'b0;
        u64          prev_addr = '0;
        fetch_data_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_q.delete();
                cnt = 0; discard = 1'b0; prev_pend = 1'b0; prev_redir = 1'b0;
                iresp_data_ok = 1'b0;
            end else begin
                if (prev_pend) begin
                    total++;
                    if (ireq_valid !== 1'b1 || ireq_addr !== prev_addr) begin
                        bad++;
                        $display("FAIL bus_hold: valid=%b addr=%h, required valid=1 addr=%h", ireq_valid, ireq_addr, prev_addr);
                    end
                end
                if (prev_redir) begin
                    total++;
                    if (f_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL redirect_flush: f_valid=%b, required 0", f_valid);
                    end
                end
                if (f_valid === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_unexpected: f_pc=%h raw=%h err=%0d, none expected", f_pc, f_raw_instr, f_error);
                    end else if ({f_pc, f_raw_instr, f_error} !== {exp_q[0].pc, exp_q[0].raw_instr, exp_q[0].error}) begin
                        bad++;
                        $display("FAIL sb_entry: got pc=%h raw=%h err=%0d, required pc=%h raw=%h err=%0d",
                                 f_pc, f_raw_instr, f_error, exp_q[0].pc, exp_q[0].raw_instr, exp_q[0].error);
                    end
                    if (!stall && !redirect_valid && exp_q.size() > 0) void'(exp_q.pop_front());
                end
                iresp_data_ok = 1'b0;
                if (ireq_valid === 1'b1) begin
                    if (cnt >= lat) begin
                        iresp_data_ok = 1'b1;
                        iresp_data    = mem_word(ireq_addr);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
                if (redirect_valid) begin
                    exp_q.delete();
                    discard = ireq_valid && !iresp_data_ok;
                    if (redirect_pc[1:0] != 2'b00) begin
                        e = '{valid: 1'b1, pc: redirect_pc, raw_instr: '0, error: INSTR_MISALIGN};
                        exp_q.push_back(e);
                    end
                end else if (iresp_data_ok) begin
                    if (discard) begin
                        discard = 1'b0;
                    end else begin
                        e = '{valid: 1'b1, pc: ireq_addr, raw_instr: mem_word(ireq_addr), error: NONE};
                        exp_q.push_back(e);
                    end
                end
                prev_pend  = ireq_valid && !iresp_data_ok;
                prev_addr  = ireq_addr;
                prev_redir = redirect_valid;
            end
        end
    endtask

    // Leaves the bench at posedge+1 of the first cycle after reset release.
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_req_forced: got %b, required 0", ireq_valid); end
        @(posedge clk); #1;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rst_req: got %b, required 0", ireq_valid); end
        total++; if (ireq_addr !== PC_RESET) begin bad++; $display("FAIL rst_addr: got %h, required %h", ireq_addr, PC_RESET); end
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL rst_fvalid: got %b, required 0", f_valid); end
        total++; if (f_pc !== '0) begin bad++; $display("FAIL rst_fpc: got %h, required 0", f_pc); end
        total++; if (f_raw_instr !== '0) begin bad++; $display("FAIL rst_raw: got %h, required 0", f_raw_instr); end
        total++; if (f_error !== NONE) begin bad++; $display("FAIL rst_err: got %0d, required NONE", f_error); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET) begin
            bad++; $display("FAIL first_req: got valid=%b addr=%h, required 1 %h", ireq_valid, ireq_addr, PC_RESET);
        end
    endtask

    task automatic test_zero_wait();
        lat = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            total++;
            if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET + u64'(4 * i)) begin
                bad++; $display("FAIL zw_addr[%0d]: got valid=%b addr=%h, required 1 %h", i, ireq_valid, ireq_addr, PC_RESET + u64'(4 * i));
            end
            if (i > 0) begin
                total++;
                if (f_valid !== 1'b1 || f_pc !== PC_RESET + u64'(4 * (i - 1))) begin
                    bad++; $display("FAIL zw_out[%0d]: got valid=%b pc=%h, required 1 %h", i, f_valid, f_pc, PC_RESET + u64'(4 * (i - 1)));
                end
            end
        end
    endtask

    task automatic test_wait3();
        int pulses = 0;
        lat = 3;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (c < 4) begin
                total++;
                if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET) begin
                    bad++; $display("FAIL w3_hold[%0d]: got valid=%b addr=%h, required 1 %h", c, ireq_valid, ireq_addr, PC_RESET);
                end
            end
            total++;
            if (f_valid !== ((c % 4 == 0) && (c > 0))) begin
                bad++; $display("FAIL w3_pulse[%0d]: got f_valid=%b, required %b", c, f_valid, (c % 4 == 0) && (c > 0));
            end
            if (f_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL w3_count: got %0d pulses, required 4", pulses); end
        lat = 0;
    endtask

    task automatic test_stall();
        u64 held;
        lat = 0;
        do_reset();
        repeat (2) begin @(posedge clk); #1; end
        stall = 1'b1;
        @(negedge clk); #1;
        held = f_pc;
        total++; if (f_valid !== 1'b1 || held !== PC_RESET + 64'd4) begin
            bad++; $display("FAIL st_first: got valid=%b pc=%h, required 1 %h", f_valid, held, PC_RESET + 64'd4);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            total++;
            if (f_valid !== 1'b1 || f_pc !== held || ireq_valid !== 1'b0) begin
                bad++; $display("FAIL st_hold[%0d]: got valid=%b pc=%h req=%b, required 1 %h 0", c, f_valid, f_pc, ireq_valid, held);
            end
        end
        @(posedge clk); #1;
        stall = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            total++;
            if (f_valid !== 1'b1 || f_pc !== held + u64'(4 * c)) begin
                bad++; $display("FAIL st_drain[%0d]: got valid=%b pc=%h, required 1 %h", c, f_valid, f_pc, held + u64'(4 * c));
            end
        end
    endtask

    task automatic test_redirect_pending();
        bit found = 1'b0;
        lat = 2;
        do_reset();
        for (int c = 0; c < 30 && !found; c++) begin
            if (ireq_valid === 1'b1 && ireq_addr === PC_RESET + 64'd8) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL rp_timeout: request to %h never seen, required within 30 cycles", PC_RESET + 64'd8);
        end else begin
            redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
            @(posedge clk); #1;
            redirect_valid = 1'b0;
            for (int c = 0; c < 2; c++) begin
                @(negedge clk); #1;
                total++;
                if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET + 64'd8 || f_valid !== 1'b0) begin
                    bad++; $display("FAIL rp_hold[%0d]: got req=%b addr=%h fv=%b, required 1 %h 0", c, ireq_valid, ireq_addr, f_valid, PC_RESET + 64'd8);
                end
            end
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); #1;
                total++;
                if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100 || f_valid !== 1'b0) begin
                    bad++; $display("FAIL rp_new[%0d]: got req=%b addr=%h fv=%b, required 1 80000100 0", c, ireq_valid, ireq_addr, f_valid);
                end
            end
            @(negedge clk); #1;
            total++;
            if (f_valid !== 1'b1 || f_pc !== 64'h8000_0100) begin
                bad++; $display("FAIL rp_out: got valid=%b pc=%h, required 1 80000100", f_valid, f_pc);
            end
        end
        lat = 0;
    endtask

    task automatic test_misalign();
        lat = 0;
        do_reset();
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b0 || f_valid !== 1'b0) begin
            bad++; $display("FAIL ma_first: got req=%b fv=%b, required 0 0", ireq_valid, f_valid);
        end
        @(negedge clk); #1;
        total++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_0102 || f_error !== INSTR_MISALIGN || f_raw_instr !== '0) begin
            bad++; $display("FAIL ma_entry: got v=%b pc=%h err=%0d raw=%h, required 1 80000102 1 0", f_valid, f_pc, f_error, f_raw_instr);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            total++;
            if (ireq_valid !== 1'b0 || f_valid !== 1'b0) begin
                bad++; $display("FAIL ma_wait[%0d]: got req=%b fv=%b, required 0 0", c, ireq_valid, f_valid);
            end
        end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0200) begin
            bad++; $display("FAIL ma_resume: got req=%b addr=%h, required 1 80000200", ireq_valid, ireq_addr);
        end
    endtask

    task automatic test_redirect_stall();
        lat = 0;
        do_reset();
        repeat (3) begin @(posedge clk); #1; end
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b1) begin bad++; $display("FAIL rs_busy: got req=%b, required 1", ireq_valid); end
        @(posedge clk); #1;
        stall = 1'b0; redirect_valid = 1'b0;
        @(negedge clk); #1;
        total++; if (f_valid !== 1'b0 || ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300) begin
            bad++; $display("FAIL rs_next: got fv=%b req=%b addr=%h, required 0 1 80000300", f_valid, ireq_valid, ireq_addr);
        end
        @(negedge clk); #1;
        total++; if (f_valid !== 1'b1 || f_pc !== 64'h8000_0300) begin
            bad++; $display("FAIL rs_out: got fv=%b pc=%h, required 1 80000300", f_valid, f_pc);
        end
    endtask

    task automatic test_wrap();
        u64 a;
        lat = 0;
        do_reset();
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        a = 64'hFFFF_FFFF_FFFF_FFF8;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            total++;
            if (ireq_valid !== 1'b1 || ireq_addr !== a) begin
                bad++; $display("FAIL wrap[%0d]: got req=%b addr=%h, required 1 %h", c, ireq_valid, ireq_addr, a);
            end
            a = a + 64'd4;
        end
    endtask

    task automatic test_reset_mid();
        lat = 2;
        do_reset();
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b0) begin bad++; $display("FAIL rm_forced: got req=%b, required 0", ireq_valid); end
        @(posedge clk); #1;
        @(negedge clk); #1;
        total++; if (ireq_addr !== PC_RESET || f_valid !== 1'b0 || f_pc !== '0 || f_raw_instr !== '0 || f_error !== NONE) begin
            bad++; $display("FAIL rm_state: got addr=%h fv=%b pc=%h raw=%h err=%0d, required %h 0 0 0 0",
                            ireq_addr, f_valid, f_pc, f_raw_instr, f_error, PC_RESET);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        total++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RESET) begin
            bad++; $display("FAIL rm_restart: got req=%b addr=%h, required 1 %h", ireq_valid, ireq_addr, PC_RESET);
        end
        lat = 0;
    endtask

    initial begin
        fork
            bus_and_scoreboard();
        join_none
        test_reset();
        test_zero_wait();
        test_wait3();
        test_stall();
        test_redirect_pending();
        test_misalign();
        test_redirect_stall();
        test_wrap();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1);
    end

endmodule
